// File: rtl/interrupt_ack_sequencer.sv
// 8259-style interrupt acknowledge sequencer: fixed-priority resolution, two-pulse
// INTA handshake, in-service tracking with normal/automatic EOI, and vector output.
module interrupt_ack_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] IRR,
   input  logic [7:0] IMR,
   input  logic [4:0] ICW2_T,
   input  logic       AEOI,
   input  logic       INTA_n,
   input  logic       EOI_cmd,
   input  logic       Address_Write_Enable,
   output logic       INT,
   output logic [2:0] Interrupt_Location,
   output logic [7:0] IRR_Clear,
   output logic [7:0] ISR,
   output logic [7:0] Data_Out,
   output logic       Data_Out_En
);

   typedef enum logic [1:0] {S_IDLE, S_ACK1, S_WAIT2, S_ACK2} state_t;

   state_t     state_q, state_d;
   logic       inta_q;
   logic       int_q, int_d;
   logic [2:0] loc_q, loc_d;
   logic [7:0] clr_q, clr_d;
   logic [7:0] isr_q, isr_d;
   logic [7:0] dout_q, dout_d;
   logic       den_q, den_d;
   logic       spur_q, spur_d;

   logic       fall, rise, take;
   logic [7:0] req;
   logic [2:0] cand_idx, isr_top;
   logic       cand_vld, isr_any, int_cond;

   assign fall = inta_q & ~INTA_n;
   assign rise = ~inta_q & INTA_n;
   assign req  = IRR & ~IMR;
   assign take = (state_q == S_IDLE) && fall;

   // Priority encoders: scan from lowest priority so the highest-priority hit wins.
   always_comb begin
      cand_idx = 3'd0;
      cand_vld = 1'b0;
      isr_top  = 3'd0;
      isr_any  = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (req[i]) begin
            cand_idx = 3'(i);
            cand_vld = 1'b1;
         end
         if (isr_q[i]) begin
            isr_top = 3'(i);
            isr_any = 1'b1;
         end
      end
   end

   assign int_cond = cand_vld && (!isr_any || (cand_idx < isr_top));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         inta_q  <= 1'b0;
         int_q   <= 1'b0;
         loc_q   <= 3'd0;
         clr_q   <= 8'h00;
         isr_q   <= 8'h00;
         dout_q  <= 8'h00;
         den_q   <= 1'b0;
         spur_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         inta_q  <= INTA_n;
         int_q   <= int_d;
         loc_q   <= loc_d;
         clr_q   <= clr_d;
         isr_q   <= isr_d;
         dout_q  <= dout_d;
         den_q   <= den_d;
         spur_q  <= spur_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (fall) state_d = S_ACK1;
         S_ACK1:  if (rise) state_d = S_WAIT2;
         S_WAIT2: if (fall) state_d = S_ACK2;
         S_ACK2:  if (rise) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      int_d  = (state_q == S_IDLE) && !fall && int_cond;
      loc_d  = loc_q;
      clr_d  = 8'h00;
      spur_d = spur_q;
      isr_d  = isr_q;
      // EOI acts on the ISR as it stood before any set made in this same cycle.
      if (EOI_cmd && isr_any)
         isr_d[isr_top] = 1'b0;
      if (take) begin
         if (cand_vld) begin
            loc_d           = cand_idx;
            clr_d[cand_idx] = 1'b1;
            isr_d[cand_idx] = 1'b1;
            spur_d          = 1'b0;
         end else begin
            loc_d  = 3'd7;
            spur_d = 1'b1;
         end
      end
      if ((state_q == S_ACK2) && rise && AEOI && !spur_q)
         isr_d[loc_q] = 1'b0;
      den_d  = (state_d == S_ACK2) ? Address_Write_Enable : 1'b0;
      dout_d = (state_d == S_ACK2) ? {ICW2_T, loc_q} : dout_q;
   end

   assign INT                = int_q;
   assign Interrupt_Location = loc_q;
   assign IRR_Clear          = clr_q;
   assign ISR                = isr_q;
   assign Data_Out           = dout_q;
   assign Data_Out_En        = den_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Bench for interrupt_ack_sequencer: directed handshake scenarios with literal
// expectations, then randomized traffic checked against a pulse-counting reference model.
module tb_interrupt_ack_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] IRR = 8'h00;
   logic [7:0] IMR = 8'h00;
   logic [4:0] ICW2_T = 5'b01000;
   logic       AEOI = 1'b0;
   logic       INTA_n = 1'b1;
   logic       EOI_cmd = 1'b0;
   logic       Address_Write_Enable = 1'b1;
   logic       INT;
   logic [2:0] Interrupt_Location;
   logic [7:0] IRR_Clear;
   logic [7:0] ISR;
   logic [7:0] Data_Out;
   logic       Data_Out_En;

   int n_cmp = 0;
   int n_bad = 0;

   interrupt_ack_sequencer dut (
      .clk                  (clk),
      .reset                (reset),
      .IRR                  (IRR),
      .IMR                  (IMR),
      .ICW2_T               (ICW2_T),
      .AEOI                 (AEOI),
      .INTA_n               (INTA_n),
      .EOI_cmd              (EOI_cmd),
      .Address_Write_Enable (Address_Write_Enable),
      .INT                  (INT),
      .Interrupt_Location   (Interrupt_Location),
      .IRR_Clear            (IRR_Clear),
      .ISR                  (ISR),
      .Data_Out             (Data_Out),
      .Data_Out_En          (Data_Out_En)
   );

   always #5 clk = ~clk;

   // Reference model: counts INTA_n low pulses (0 = idle, 1 = first low, 2 = between, 3 = second low).
   int         m_pulse = 0;
   logic       m_prev = 1'b0;
   logic       m_int = 1'b0;
   logic [2:0] m_loc = 3'd0;
   logic [7:0] m_clr = 8'h00;
   logic [7:0] m_isr = 8'h00;
   logic [7:0] m_dout = 8'h00;
   logic       m_den = 1'b0;
   logic       m_spur = 1'b0;

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++)
         if (v[i]) return i;
      return 8;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pulse = 0; m_prev = 1'b0; m_int = 1'b0; m_loc = 3'd0; m_clr = 8'h00;
         m_isr = 8'h00; m_dout = 8'h00; m_den = 1'b0; m_spur = 1'b0;
      end else begin
         int   cand, top;
         logic fl, rs;
         logic [7:0] isr_n;
         fl    = m_prev && !INTA_n;
         rs    = !m_prev && INTA_n;
         cand  = lowest(IRR & ~IMR);
         top   = lowest(m_isr);
         m_int = (m_pulse == 0) && !fl && (cand < 8) && (cand < top);
         m_clr = 8'h00;
         isr_n = m_isr;
         if (EOI_cmd && top < 8) isr_n[top] = 1'b0;
         case (m_pulse)
            0: if (fl) begin
                  m_pulse = 1;
                  if (cand < 8) begin
                     m_loc = 3'(cand); isr_n[cand] = 1'b1; m_clr = 8'(1 << cand); m_spur = 1'b0;
                  end else begin
                     m_loc = 3'd7; m_spur = 1'b1;
                  end
               end
            1: if (rs) m_pulse = 2;
            2: if (fl) begin
                  m_pulse = 3; m_dout = {ICW2_T, m_loc}; m_den = Address_Write_Enable;
               end
            default: if (rs) begin
                  m_pulse = 0; m_den = 1'b0;
                  if (AEOI && !m_spur) isr_n[m_loc] = 1'b0;
               end else begin
                  m_dout = {ICW2_T, m_loc}; m_den = Address_Write_Enable;
               end
         endcase
         m_isr  = isr_n;
         m_prev = INTA_n;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("int", 32'(INT), 32'(m_int));
      chk("loc", 32'(Interrupt_Location), 32'(m_loc));
      chk("irr_clear", 32'(IRR_Clear), 32'(m_clr));
      chk("isr", 32'(ISR), 32'(m_isr));
      chk("dout_en", 32'(Data_Out_En), 32'(m_den));
      if (m_pulse == 3) chk("dout", 32'(Data_Out), 32'(m_dout));
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_pair();
      INTA_n = 1'b0; step(1);
      IRR = 8'h00;   step(1);
      INTA_n = 1'b1; step(2);
      INTA_n = 1'b0; step(2);
      INTA_n = 1'b1; step(2);
   endtask

   initial begin
      #1 reset = 1'b1;
      step(2);
      chk("rst_int", 32'(INT), 0);
      chk("rst_isr", 32'(ISR), 0);
      chk("rst_loc", 32'(Interrupt_Location), 0);
      chk("rst_den", 32'(Data_Out_En), 0);
      reset = 1'b0;
      step(2);

      // Single request on IR3, vector base 0x40
      IRR = 8'h08; step(1);
      chk("v1_int_hi", 32'(INT), 1);
      INTA_n = 1'b0; step(1);
      chk("v1_loc", 32'(Interrupt_Location), 3);
      chk("v1_isr", 32'(ISR), 32'h08);
      chk("v1_clr", 32'(IRR_Clear), 32'h08);
      chk("v1_int_lo", 32'(INT), 0);
      IRR = 8'h00; step(1);
      chk("v1_clr_once", 32'(IRR_Clear), 0);
      INTA_n = 1'b1; step(2);
      INTA_n = 1'b0; step(1);
      chk("v1_dout", 32'(Data_Out), 32'h43);
      chk("v1_den", 32'(Data_Out_En), 1);
      INTA_n = 1'b1; step(1);
      chk("v1_den_off", 32'(Data_Out_En), 0);
      chk("v1_isr_kept", 32'(ISR), 32'h08);
      EOI_cmd = 1'b1; step(1); EOI_cmd = 1'b0;
      chk("v1_eoi", 32'(ISR), 0);

      // Masked IR2, IR5 acknowledged with automatic EOI
      IRR = 8'h24; IMR = 8'h04; AEOI = 1'b1; step(1);
      INTA_n = 1'b0; step(1);
      chk("v2_loc", 32'(Interrupt_Location), 5);
      chk("v2_isr", 32'(ISR), 32'h20);
      IRR = 8'h04; INTA_n = 1'b1; step(2);
      INTA_n = 1'b0; step(2);
      INTA_n = 1'b1; step(1);
      chk("v2_aeoi", 32'(ISR), 0);
      AEOI = 1'b0; IMR = 8'h00; IRR = 8'h00; step(1);

      // Priority against in-service level and non-specific EOI
      IRR = 8'h10; step(1);
      do_pair();
      chk("v3_isr", 32'(ISR), 32'h10);
      IRR = 8'h40; step(2);
      chk("v3_int_blocked", 32'(INT), 0);
      IRR = 8'h02; step(2);
      chk("v3_int_pre", 32'(INT), 1);
      do_pair();
      chk("v3_isr_nest", 32'(ISR), 32'h12);
      EOI_cmd = 1'b1; step(1); EOI_cmd = 1'b0;
      chk("v3_eoi", 32'(ISR), 32'h10);

      // Spurious acknowledge with the vector drive disabled
      IRR = 8'h00; Address_Write_Enable = 1'b0; step(1);
      INTA_n = 1'b0; step(1);
      chk("v4_loc", 32'(Interrupt_Location), 7);
      chk("v4_isr", 32'(ISR), 32'h10);
      INTA_n = 1'b1; step(2);
      INTA_n = 1'b0; step(1);
      chk("v4_dout", 32'(Data_Out), 32'h47);
      chk("v4_den", 32'(Data_Out_En), 0);
      INTA_n = 1'b1; step(2);
      Address_Write_Enable = 1'b1;

      // Reset while waiting for the second pulse, released with INTA_n still low
      IRR = 8'h08; step(1);
      INTA_n = 1'b0; step(1);
      INTA_n = 1'b1; step(2);
      INTA_n = 1'b0; reset = 1'b1; #1;
      chk("v5_rst_den", 32'(Data_Out_En), 0);
      chk("v5_rst_isr", 32'(ISR), 0);
      chk("v5_rst_loc", 32'(Interrupt_Location), 0);
      step(1); reset = 1'b0; step(2);
      chk("v5_no_fall", 32'(ISR), 0);
      INTA_n = 1'b1; step(1);
      INTA_n = 1'b0; step(1);
      chk("v5_loc", 32'(Interrupt_Location), 3);
      chk("v5_isr", 32'(ISR), 32'h08);
      IRR = 8'h00; INTA_n = 1'b1; step(2);
      INTA_n = 1'b0; step(1);
      chk("v5_dout", 32'(Data_Out), 32'h43);
      chk("v5_den", 32'(Data_Out_En), 1);
      INTA_n = 1'b1; step(2);
      EOI_cmd = 1'b1; step(1); EOI_cmd = 1'b0;

      // Randomized traffic against the reference model
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(3) == 0) INTA_n = ~INTA_n;
         if ($urandom_range(7) == 0) IRR = 8'($urandom) & 8'($urandom);
         if ($urandom_range(15) == 0) IMR = 8'($urandom) & 8'($urandom) & 8'($urandom);
         EOI_cmd = ($urandom_range(9) == 0);
         if ($urandom_range(15) == 0) AEOI = 1'($urandom);
         if ($urandom_range(7) == 0) Address_Write_Enable = 1'($urandom);
         if ($urandom_range(63) == 0) ICW2_T = 5'($urandom);
         reset = ($urandom_range(299) == 0);
         step(1);
      end
      reset = 1'b0; EOI_cmd = 1'b0;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
